// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for a two-write-port register file: grants up to two
// requesters per cycle in round-robin order and can sweep the file to zero.
module regfile_wb_arbiter #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int SIZE       = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          init_start,
   output logic                          init_busy,
   output logic                          init_done,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          write_En,
   output logic [ADDR_WIDTH-1:0]         write_Addr,
   output logic [DATA_WIDTH-1:0]         write_Data,
   output logic                          write_En_2,
   output logic [ADDR_WIDTH-1:0]         write_Addr_2,
   output logic [DATA_WIDTH-1:0]         write_Data_2,
   output logic                          o_dbg_state
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int KW = (SIZE > 2) ? $clog2(SIZE / 2) : 1;

   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

   state_t                r_state;
   logic [PW-1:0]         r_p;
   logic [KW-1:0]         r_k;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_en1;
   logic                  r_en2;
   logic [ADDR_WIDTH-1:0] r_addr1;
   logic [ADDR_WIDTH-1:0] r_addr2;
   logic [DATA_WIDTH-1:0] r_data1;
   logic [DATA_WIDTH-1:0] r_data2;

   logic [ADDR_WIDTH-1:0] w_addr [N_REQ];
   logic [DATA_WIDTH-1:0] w_data [N_REQ];
   logic                  w_arb_en;
   logic [PW:0]           w_sum;
   logic [PW-1:0]         w_idx;
   logic                  w_a_found;
   logic                  w_b_found;
   logic [PW-1:0]         w_a_idx;
   logic [PW-1:0]         w_b_idx;
   logic [ADDR_WIDTH-1:0] w_a_addr;
   logic [ADDR_WIDTH-1:0] w_b_addr;
   logic [DATA_WIDTH-1:0] w_a_data;
   logic [DATA_WIDTH-1:0] w_b_data;
   logic [N_REQ-1:0]      w_ready;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_addr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] x);
      return (x == PW'(N_REQ - 1)) ? '0 : x + 1'b1;
   endfunction

   // Handshake: requester i transfers in a cycle where req_valid[i] and
   // req_ready[i] are both high; req_ready is a pure function of req_valid,
   // req_addr, the pointer and the state, so valid must never wait on ready.
   always_comb begin
      w_arb_en  = !rst && (r_state == ST_IDLE) && !init_start;
      w_sum     = '0;
      w_idx     = '0;
      w_a_found = 1'b0;
      w_b_found = 1'b0;
      w_a_idx   = '0;
      w_b_idx   = '0;
      w_a_addr  = '0;
      w_b_addr  = '0;
      w_a_data  = '0;
      w_b_data  = '0;
      w_ready   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_p} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(N_REQ)) w_sum = w_sum - (PW+1)'(N_REQ);
         w_idx = w_sum[PW-1:0];
         if (w_arb_en && req_valid[w_idx]) begin
            if (!w_a_found) begin
               w_a_found = 1'b1;
               w_a_idx   = w_idx;
               w_a_addr  = w_addr[w_idx];
               w_a_data  = w_data[w_idx];
            end else if (!w_b_found && (w_addr[w_idx] != w_a_addr)) begin
               // same destination as A waits a cycle: no same-cycle WAW
               w_b_found = 1'b1;
               w_b_idx   = w_idx;
               w_b_addr  = w_addr[w_idx];
               w_b_data  = w_data[w_idx];
            end
         end
      end
      if (w_a_found) w_ready[w_a_idx] = 1'b1;
      if (w_b_found) w_ready[w_b_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_p     <= '0;
         r_k     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_en1   <= 1'b0;
         r_en2   <= 1'b0;
         r_addr1 <= '0;
         r_addr2 <= '0;
         r_data1 <= '0;
         r_data2 <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // address 0 still takes its slot but the write is dropped
               r_en1 <= w_a_found && (w_a_addr != '0);
               r_en2 <= w_b_found && (w_b_addr != '0);
               if (w_a_found) begin
                  r_addr1 <= w_a_addr;
                  r_data1 <= w_a_data;
               end
               if (w_b_found) begin
                  r_addr2 <= w_b_addr;
                  r_data2 <= w_b_data;
               end
               if (w_b_found)      r_p <= f_next(w_b_idx);
               else if (w_a_found) r_p <= f_next(w_a_idx);
               if (init_start) begin
                  r_state <= ST_CLEAR;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               r_en1   <= 1'b1;
               r_addr1 <= ADDR_WIDTH'({r_k, 1'b0});
               r_data1 <= '0;
               r_en2   <= 1'b1;
               r_addr2 <= ADDR_WIDTH'({r_k, 1'b1});
               r_data2 <= '0;
               r_k     <= r_k + 1'b1;
               if (r_k == KW'(SIZE / 2 - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = w_ready;
   assign init_busy    = r_busy;
   assign init_done    = r_done;
   assign write_En     = r_en1;
   assign write_Addr   = r_addr1;
   assign write_Data   = r_data1;
   assign write_En_2   = r_en2;
   assign write_Addr_2 = r_addr2;
   assign write_Data_2 = r_data2;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: reference round-robin model feeding an
// expected-write queue, plus directed sweep and reset-abort sequences.
module tb_regfile_wb_arbiter;

   localparam int N_REQ = 4;
   localparam int DW    = 32;
   localparam int AW    = 6;
   localparam int SIZE  = 64;
   localparam int HALF  = SIZE / 2;
   localparam int EW    = 2 * (1 + AW + DW);

   logic                clk = 1'b0;
   logic                rst;
   logic                init_start;
   logic                init_busy;
   logic                init_done;
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ-1:0]    req_ready;
   logic                write_En;
   logic [AW-1:0]       write_Addr;
   logic [DW-1:0]       write_Data;
   logic                write_En_2;
   logic [AW-1:0]       write_Addr_2;
   logic [DW-1:0]       write_Data_2;
   logic                dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int m_p      = 0;
   logic [EW-1:0] exp_q[$];

   regfile_wb_arbiter #(.N_REQ(N_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SIZE)) dut (
      .clk(clk), .rst(rst), .init_start(init_start),
      .init_busy(init_busy), .init_done(init_done),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .write_En(write_En), .write_Addr(write_Addr), .write_Data(write_Data),
      .write_En_2(write_En_2), .write_Addr_2(write_Addr_2), .write_Data_2(write_Data_2),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference arbiter: build the rotation-ordered list of valid requesters,
   // take the first, then the first later one with a different address.
   task automatic model_grant(input logic [3:0] v, input logic [N_REQ*AW-1:0] a,
                              input logic [N_REQ*DW-1:0] d,
                              output logic [3:0] mask, output logic [EW-1:0] ent);
      int order[$];
      int ga, gb;
      logic e1, e2;
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] d1, d2;
      ga = -1; gb = -1;
      e1 = 0; e2 = 0; a1 = 0; a2 = 0; d1 = 0; d2 = 0; mask = 0;
      for (int i = 0; i < N_REQ; i++)
         if (v[(m_p + i) % N_REQ]) order.push_back((m_p + i) % N_REQ);
      if (order.size() > 0) ga = order[0];
      for (int j = 1; j < order.size(); j++)
         if (gb < 0 && a[order[j]*AW +: AW] != a[ga*AW +: AW]) gb = order[j];
      if (ga >= 0) begin
         mask[ga] = 1'b1;
         a1 = a[ga*AW +: AW];
         d1 = d[ga*DW +: DW];
         e1 = (a1 != 0);
         m_p = (ga + 1) % N_REQ;
      end
      if (gb >= 0) begin
         mask[gb] = 1'b1;
         a2 = a[gb*AW +: AW];
         d2 = d[gb*DW +: DW];
         e2 = (a2 != 0);
         m_p = (gb + 1) % N_REQ;
      end
      ent = {e1, a1, d1, e2, a2, d2};
   endtask

   task automatic check_ports();
      logic [EW-1:0] ent;
      logic e1, e2;
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] d1, d2;
      ent = exp_q.pop_front();
      {e1, a1, d1, e2, a2, d2} = ent;
      check("wr_en1", 64'(write_En), 64'(e1));
      check("wr_en2", 64'(write_En_2), 64'(e2));
      if (e1) begin
         check("wr_addr1", 64'(write_Addr), 64'(a1));
         check("wr_data1", 64'(write_Data), 64'(d1));
      end
      if (e2) begin
         check("wr_addr2", 64'(write_Addr_2), 64'(a2));
         check("wr_data2", 64'(write_Data_2), 64'(d2));
      end
   endtask

   // One arbitration cycle: starts and ends 1 time unit after a rising edge.
   task automatic cycle(input logic [3:0] v, input logic [N_REQ*AW-1:0] a,
                        input logic [N_REQ*DW-1:0] d, output logic [3:0] seen);
      logic [3:0] mask;
      logic [EW-1:0] ent;
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      @(negedge clk);
      seen = req_ready;
      model_grant(v, a, d, mask, ent);
      check("req_ready", 64'(req_ready), 64'(mask));
      exp_q.push_back(ent);
      @(posedge clk); #1;
      check_ports();
   endtask

   function automatic logic [N_REQ*DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [N_REQ*AW-1:0] a_rr;
   logic [N_REQ*AW-1:0] a_tmp;
   logic [N_REQ*DW-1:0] d_tmp;
   logic [3:0]          seen;

   initial begin
      a_rr       = {6'd4, 6'd3, 6'd2, 6'd1};
      rst        = 1'b1;
      init_start = 1'b0;
      req_valid  = 4'hF;
      req_addr   = a_rr;
      req_data   = rand_data();

      repeat (2) begin
         @(negedge clk);
         check("rst_ready", 64'(req_ready), 64'(0));
         check("rst_en1", 64'(write_En), 64'(0));
         check("rst_en2", 64'(write_En_2), 64'(0));
         check("rst_addr1", 64'(write_Addr), 64'(0));
         check("rst_data1", 64'(write_Data), 64'(0));
         check("rst_addr2", 64'(write_Addr_2), 64'(0));
         check("rst_data2", 64'(write_Data_2), 64'(0));
         check("rst_busy", 64'(init_busy), 64'(0));
         check("rst_done", 64'(init_done), 64'(0));
         check("rst_state", 64'(dbg_state), 64'(0));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      m_p = 0;

      for (int c = 0; c < 4; c++) begin
         cycle(4'hF, a_rr, rand_data(), seen);
         check("rr_pair", 64'(seen), 64'((c % 2 == 0) ? 4'b0011 : 4'b1100));
      end

      a_tmp = {6'd9, 6'd7, 6'd5, 6'd5};
      d_tmp = rand_data();
      cycle(4'b0111, a_tmp, d_tmp, seen);
      check("collide_grant", 64'(seen), 64'(4'b0101));
      cycle(4'b0010, a_tmp, d_tmp, seen);
      check("collide_retry", 64'(seen), 64'(4'b0010));

      a_tmp = {6'd9, 6'd7, 6'd5, 6'd0};
      d_tmp = {96'h0, 32'hDEADBEEF};
      cycle(4'b0001, a_tmp, d_tmp, seen);
      check("addr0_ready", 64'(seen), 64'(4'b0001));
      check("addr0_en", 64'(write_En), 64'(0));

      for (int c = 0; c < 40; c++) begin
         for (int r = 0; r < N_REQ; r++) a_tmp[r*AW +: AW] = AW'($urandom_range(0, 3));
         cycle(4'($urandom_range(0, 15)), a_tmp, rand_data(), seen);
      end
      cycle(4'b0000, a_rr, rand_data(), seen);

      // Full sweep with requesters valid and a second init_start in cycle 10.
      req_valid = 4'hF;
      req_addr  = a_rr;
      for (int c = 0; c <= HALF + 2; c++) begin
         init_start = (c == 0 || c == 10);
         if (c == HALF + 1) req_valid = 4'h0;
         @(negedge clk);
         if (c <= HALF) check("sweep_ready", 64'(req_ready), 64'(0));
         check("sweep_busy", 64'(init_busy), 64'(c >= 1 && c <= HALF));
         check("sweep_done", 64'(init_done), 64'(c == HALF + 1));
         check("sweep_en1", 64'(write_En), 64'(c >= 2 && c <= HALF + 1));
         check("sweep_en2", 64'(write_En_2), 64'(c >= 2 && c <= HALF + 1));
         if (c >= 2 && c <= HALF + 1) begin
            check("sweep_addr1", 64'(write_Addr), 64'(2 * (c - 2)));
            check("sweep_addr2", 64'(write_Addr_2), 64'(2 * (c - 2) + 1));
            check("sweep_data1", 64'(write_Data), 64'(0));
            check("sweep_data2", 64'(write_Data_2), 64'(0));
         end
         @(posedge clk); #1;
      end
      init_start = 1'b0;

      // Sweep aborted by reset in cycle 8.
      req_valid = 4'h0;
      for (int c = 0; c <= HALF + 8; c++) begin
         init_start = (c == 0);
         rst        = (c == 8);
         @(negedge clk);
         if (c >= 1 && c <= 8) check("abort_busy_pre", 64'(init_busy), 64'(1));
         if (c >= 9) begin
            check("abort_busy", 64'(init_busy), 64'(0));
            check("abort_done", 64'(init_done), 64'(0));
            check("abort_en1", 64'(write_En), 64'(0));
            check("abort_en2", 64'(write_En_2), 64'(0));
         end
         if (c == 9) check("abort_state", 64'(dbg_state), 64'(0));
         @(posedge clk); #1;
      end
      rst        = 1'b0;
      init_start = 1'b0;
      m_p        = 0;

      cycle(4'hF, a_rr, rand_data(), seen);
      check("post_abort_rr", 64'(seen), 64'(4'b0011));
      for (int c = 0; c < 10; c++) begin
         for (int r = 0; r < N_REQ; r++) a_tmp[r*AW +: AW] = AW'($urandom_range(0, 5));
         cycle(4'($urandom_range(0, 15)), a_tmp, rand_data(), seen);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and initialisation sequencer for the two-write-port register file. It accepts results from `N_REQ` execution units over valid/ready handshakes and grants up to two per cycle in round-robin order. Granted writes are registered onto the register file's write port 1 and write port 2. On command it also sweeps the register file to zero, using both write ports, while stalling all requesters.

## Interface
- `N_REQ`, 4: number of write-back requesters; must be ≥ 2.
- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 6: register address width.
- `SIZE`, 64: register file entries; must be even and ≤ 2^`ADDR_WIDTH`.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: **synchronous, active-high reset**; one clock, sampled on the rising edge of `clk`.
- `init_start`, in, 1: request a zero sweep; acted on only in IDLE.
- `init_busy`, out, 1: high while the FSM is in CLEAR.
- `init_done`, out, 1: one-cycle pulse, coincident with the last sweep write on the ports.
- `req_valid`, in, `N_REQ`: per-requester valid.
- `req_addr`, in, `N_REQ`×`ADDR_WIDTH`: destination register.
- `req_data`, in, `N_REQ`×`DATA_WIDTH`: result data.
- `req_ready`, out, `N_REQ`: combinational grant; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `write_En`, `write_Addr`, `write_Data`, out, 1/`ADDR_WIDTH`/`DATA_WIDTH`: register file write port 1, registered.
- `write_En_2`, `write_Addr_2`, `write_Data_2`, out, 1/`ADDR_WIDTH`/`DATA_WIDTH`: register file write port 2, registered.

## Operation
- FSM states: IDLE and CLEAR.
- Reset behaviour:
  - FSM enters IDLE; round-robin pointer `p` = 0; sweep counter `k` = 0.
  - All registered outputs (`write_*`, `init_busy`, `init_done`) are 0.
  - `req_ready` is forced to 0 while `rst` is high.
- Arbitration in IDLE, when `init_start` is low:
  - Scan requesters `p`, `p+1`, …, `p+N_REQ-1` (mod `N_REQ`).
  - First valid requester A is granted to port 1.
  - Next valid requester B after A whose `req_addr` differs from A's is granted to port 2. A requester with the same address as A is skipped this cycle; it keeps its data and waits (no same-cycle write-after-write).
  - `req_ready` is high only for A and B.
- Pointer update:
  - If B was granted, `p` ← (B+1) mod `N_REQ`.
  - Else if only A was granted, `p` ← (A+1) mod `N_REQ`.
  - Else `p` is unchanged.
- Address 0:
  - The request is granted and consumes its port slot.
  - The corresponding `write_En`/`write_En_2` is registered low, so the write is dropped (r0 stays zero).
- Output register, loaded each edge:
  - Port 1 gets A's address and data with enable 1; port 2 gets B's with enable 1.
  - An ungranted port gets enable 0; its address and data hold their previous values.
- `init_start` high in IDLE:
  - `req_ready` is 0 in that cycle.
  - FSM goes to CLEAR with `k` = 0.
- CLEAR:
  - `req_ready` is 0 for all requesters.
  - Each edge loads port 1 = (2k, 0, en 1) and port 2 = (2k+1, 0, en 1), then increments `k`.
  - When `k` = `SIZE`/2−1 at the edge, the FSM returns to IDLE and `init_done` is registered to 1 for one cycle.
- `init_start` while in CLEAR is ignored; it is not queued.
- `rst` asserted mid-sweep: the FSM aborts to IDLE, no `init_done` pulse is produced, and the outputs are cleared.

## Timing
- Write-back latency: a handshake in cycle t drives the write port during cycle t+1. The register file updates at the end of t+1, so the data is readable from cycle t+2.
- Throughput: up to 2 writes per cycle; no internal buffering beyond the output register.
- `req_ready` depends combinationally on `req_valid`, `req_addr`, `p` and the FSM state. Requesters must not make `req_valid` depend on `req_ready`.
- Sweep timing, with `init_start` sampled high at the end of cycle 0:
  - `init_busy` is high in cycles 1..`SIZE`/2.
  - Sweep writes are on the ports in cycles 2..`SIZE`/2+1.
  - `init_done` is high in cycle `SIZE`/2+1.
  - `req_ready` may rise again in cycle `SIZE`/2+1.

## Test plan
- **Reset:** hold `rst` for 2 cycles with all `req_valid`=1 → `req_ready`=0 and all outputs 0. After release, with `p`=0, requesters 0 and 1 are granted.
- **Round robin:** with defaults, all 4 requesters valid continuously with distinct addresses 1..4 → grant pairs per cycle {0,1}, {2,3}, {0,1}, …. Each write appears on the ports the cycle after its grant, with matching data.
- **Address collision:** requesters 0, 1 and 2 valid with addresses 5, 5, 7 and `p`=0 → grants go to 0 (port 1) and 2 (port 2). Requester 1 is granted next cycle on port 1.
- **Address 0:** single requester with address 0 and data 0xDEADBEEF → `req_ready`=1 and next cycle `write_En`=0.
- **Sweep:** with `SIZE`=64, pulse `init_start` in cycle 0 with requesters valid →
  - busy in cycles 1..32;
  - port pairs (0,1) … (62,63) with data 0 in cycles 2..33;
  - `init_done` in cycle 33;
  - no `req_ready` during cycles 0..32;
  - a second `init_start` in cycle 10 is ignored.
- **Reset mid-sweep:** assert `rst` in cycle 8 of a sweep → next cycle IDLE with `write_En`=`write_En_2`=0 and no `init_done` pulse.
